// File: rtl/ks_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package ks_pkg;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Rank 0 plus one rank per group of prefix levels (the last one is the output register).
    function automatic int ks_latency(input int width, input int lps);
        int l;
        l = clog2(width);
        return (l + lps - 1) / lps + 1;
    endfunction

endpackage

// File: rtl/pipelined_ks_adder_if.sv
// Valid/ready operand and result stream of the pipelined adder.
interface pipelined_ks_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level: black cells at distance DIST, pass-through below.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  pg_t [WIDTH-1:0] pg_i,
    output pg_t [WIDTH-1:0] pg_o
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi >= DIST) begin : g_cell
            assign pg_o[gi].g = pg_i[gi].g | (pg_i[gi].p & pg_i[gi-DIST].g);
            assign pg_o[gi].p = pg_i[gi].p & pg_i[gi-DIST].p;
        end else begin : g_pass
            assign pg_o[gi] = pg_i[gi];
        end
    end

endmodule

// File: rtl/pipelined_ks_adder.sv
// Pipelined Kogge-Stone adder/subtractor with one shared advance enable across all ranks.
module pipelined_ks_adder
    import ks_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 flush,
    pipelined_ks_adder_if.slave bus
);

    localparam int L  = clog2(WIDTH);
    localparam int NS = ks_latency(WIDTH, LEVELS_PER_STAGE) - 1;

    logic adv;

    logic [WIDTH-1:0] bp_d;
    logic             c0_d;
    pg_t  [WIDTH-1:0] pg0_d;

    pg_t  [WIDTH-1:0] st_pg_q [NS];
    pg_t  [WIDTH-1:0] st_pg_d [NS];
    logic [WIDTH-1:0] st_p_q  [NS];
    logic [NS-1:0]    st_c0_q;
    logic [NS-1:0]    st_amsb_q;
    logic [NS-1:0]    st_bmsb_q;
    logic [NS-1:0]    st_vld_q;

    pg_t  [WIDTH-1:0] fin_pg;
    logic [WIDTH-1:0] fin_g;
    logic [WIDTH-1:0] unused_fin_p;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;
    logic             out_zero_q;

    assign adv = !out_valid_q || bus.out_ready;

    // Subtraction is A + ~B + 1; the carry-in is folded into the bit-0 generate.
    always_comb begin
        bp_d = bus.in_sub ? ~bus.in_b : bus.in_b;
        c0_d = bus.in_sub | bus.in_cin;
        for (int i = 0; i < WIDTH; i++) begin
            pg0_d[i].p = bus.in_a[i] ^ bp_d[i];
            pg0_d[i].g = bus.in_a[i] & bp_d[i];
        end
        pg0_d[0].g = pg0_d[0].g | (pg0_d[0].p & c0_d);
    end

    for (genvar gi = 0; gi < L; gi++) begin : g_level
        pg_t [WIDTH-1:0] pg_in;
        pg_t [WIDTH-1:0] pg_out;

        if (gi % LEVELS_PER_STAGE == 0) begin : g_from_rank
            assign pg_in = st_pg_q[gi / LEVELS_PER_STAGE];
        end else begin : g_chain
            assign pg_in = g_level[gi-1].pg_out;
        end

        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << gi)
        ) u_level (
            .pg_i (pg_in),
            .pg_o (pg_out)
        );
    end

    assign st_pg_d[0] = pg0_d;
    for (genvar gi = 1; gi < NS; gi++) begin : g_rank_in
        assign st_pg_d[gi] = g_level[gi*LEVELS_PER_STAGE-1].pg_out;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int s = 0; s < NS; s++) begin
                st_pg_q[s] <= st_pg_d[s];
            end
            st_p_q[0]    <= bus.in_a ^ bp_d;
            st_c0_q[0]   <= c0_d;
            st_amsb_q[0] <= bus.in_a[WIDTH-1];
            st_bmsb_q[0] <= bp_d[WIDTH-1];
            for (int s = 1; s < NS; s++) begin
                st_p_q[s]    <= st_p_q[s-1];
                st_c0_q[s]   <= st_c0_q[s-1];
                st_amsb_q[s] <= st_amsb_q[s-1];
                st_bmsb_q[s] <= st_bmsb_q[s-1];
            end
        end
    end

    // Group generates after the last level are the carries out of each bit.
    assign fin_pg = g_level[L-1].pg_out;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fin
        assign fin_g[gi]        = fin_pg[gi].g;
        assign unused_fin_p[gi] = fin_pg[gi].p;
    end

    always_comb begin
        sum_d  = st_p_q[NS-1] ^ {fin_g[WIDTH-2:0], st_c0_q[NS-1]};
        cout_d = fin_g[WIDTH-1];
        ovf_d  = (st_amsb_q[NS-1] == st_bmsb_q[NS-1]) && (sum_d[WIDTH-1] != st_amsb_q[NS-1]);
        zero_d = ~|sum_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_vld_q    <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else if (flush) begin
            st_vld_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            st_vld_q[0] <= bus.in_valid;
            for (int s = 1; s < NS; s++) begin
                st_vld_q[s] <= st_vld_q[s-1];
            end
            out_valid_q <= st_vld_q[NS-1];
            out_sum_q   <= sum_d;
            out_cout_q  <= cout_d;
            out_ovf_q   <= ovf_d;
            out_zero_q  <= zero_d;
        end
    end

    // in_ready is combinational from out_ready through adv.
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_pipelined_ks_adder.sv
// Directed bench for three adder configurations: 32/2, 16/1 and a non-power-of-two 13/3.
module tb_pipelined_ks_adder;

    localparam int LAT32 = 4;
    localparam int LAT16 = 5;
    localparam int LAT13 = 3;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        flush   = 1'b0;
    logic [31:0] a_drv   = '0;
    logic [31:0] b_drv   = '0;
    logic        cin_drv = 1'b0;
    logic        sub_drv = 1'b0;
    logic        rdy_drv = 1'b1;
    logic [2:0]  vld_drv = '0;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    pipelined_ks_adder_if #(.WIDTH(32)) bus32 ();
    pipelined_ks_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_ks_adder_if #(.WIDTH(13)) bus13 ();

    assign bus32.in_valid  = vld_drv[0];
    assign bus32.in_a      = a_drv;
    assign bus32.in_b      = b_drv;
    assign bus32.in_cin    = cin_drv;
    assign bus32.in_sub    = sub_drv;
    assign bus32.out_ready = rdy_drv;

    assign bus16.in_valid  = vld_drv[1];
    assign bus16.in_a      = a_drv[15:0];
    assign bus16.in_b      = b_drv[15:0];
    assign bus16.in_cin    = cin_drv;
    assign bus16.in_sub    = sub_drv;
    assign bus16.out_ready = rdy_drv;

    assign bus13.in_valid  = vld_drv[2];
    assign bus13.in_a      = a_drv[12:0];
    assign bus13.in_b      = b_drv[12:0];
    assign bus13.in_cin    = cin_drv;
    assign bus13.in_sub    = sub_drv;
    assign bus13.out_ready = rdy_drv;

    pipelined_ks_adder #(.WIDTH(32), .LEVELS_PER_STAGE(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));
    pipelined_ks_adder #(.WIDTH(16), .LEVELS_PER_STAGE(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus16));
    pipelined_ks_adder #(.WIDTH(13), .LEVELS_PER_STAGE(3)) dut13 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus13));

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } mon_t;

    function automatic mon_t mon(input int sel);
        mon_t m;
        case (sel)
            0:       m = {bus32.out_valid, bus32.in_ready, bus32.out_sum,
                          bus32.out_cout, bus32.out_ovf, bus32.out_zero};
            1:       m = {bus16.out_valid, bus16.in_ready, 16'h0, bus16.out_sum,
                          bus16.out_cout, bus16.out_ovf, bus16.out_zero};
            default: m = {bus13.out_valid, bus13.in_ready, 19'h0, bus13.out_sum,
                          bus13.out_cout, bus13.out_ovf, bus13.out_zero};
        endcase
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the target DUT idle; checks the exact latency and the result.
    task automatic single(input int sel, input int lat, input string tag,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub,
                          input logic [31:0] es, input logic ec, input logic eo, input logic ez);
        mon_t m;
        a_drv = a; b_drv = b; cin_drv = cin; sub_drv = sub;
        vld_drv[sel] = 1'b1;
        #1;
        m = mon(sel);
        check({tag, "_ready"}, m.ready, 1);
        @(negedge clk);
        vld_drv = '0;
        repeat (lat - 2) @(negedge clk);
        m = mon(sel);
        check({tag, "_early"}, m.valid, 0);
        @(negedge clk);
        m = mon(sel);
        check({tag, "_valid"}, m.valid, 1);
        check({tag, "_sum"}, m.sum, es);
        check({tag, "_flags"}, {m.cout, m.ovf, m.zero}, {ec, eo, ez});
        $display("txn %s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b zero=%b",
                 tag, a, b, cin, sub, m.sum, m.cout, m.ovf, m.zero);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mon_t        m;
        mon_t        held;
        logic [31:0] op_a [20];
        logic [31:0] op_b [20];
        logic        op_c [20];
        logic        op_s [20];
        logic [31:0] exp_sum [20];
        logic [2:0]  exp_flg [20];
        logic [31:0] bpm;
        logic [32:0] full;
        int          tx;
        int          rx;
        int          cyc;

        // Reset held with live input traffic on every DUT.
        rst_n = 1'b0;
        vld_drv = 3'b111;
        a_drv = $urandom; b_drv = $urandom;
        cin_drv = 1'($urandom); sub_drv = 1'($urandom);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            m = mon(s);
            check($sformatf("rst%0d_valid", s), m.valid, 0);
            check($sformatf("rst%0d_sum", s), m.sum, 0);
            check($sformatf("rst%0d_flags", s), {m.cout, m.ovf, m.zero}, 3'b000);
            check($sformatf("rst%0d_ready", s), m.ready, 1);
        end
        vld_drv = '0;
        rst_n = 1'b1;
        @(negedge clk);

        single(0, LAT32, "add_full_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single(0, LAT32, "sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
               32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        single(0, LAT32, "sub_equal", 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1,
               32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single(0, LAT32, "add_cin_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0,
               32'h8000_0001, 1'b0, 1'b1, 1'b0);
        single(0, LAT32, "sub_borrow_cin_ignored", 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        single(2, LAT13, "w13_full_carry", 32'h0000_1FFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single(2, LAT13, "w13_ovf", 32'h0000_0FFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_1000, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream with a 3-cycle output stall.
        for (int i = 0; i < 20; i++) begin
            op_a[i] = $urandom; op_b[i] = $urandom;
            op_c[i] = 1'($urandom); op_s[i] = 1'($urandom);
        end
        op_a[5] = 32'hFFFF_FFFF; op_b[5] = 32'h0; op_c[5] = 1'b1; op_s[5] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bpm  = op_s[i] ? ~op_b[i] : op_b[i];
            full = {1'b0, op_a[i]} + {1'b0, bpm} + {32'h0, (op_s[i] | op_c[i])};
            exp_sum[i] = full[31:0];
            exp_flg[i] = {full[32], (op_a[i][31] == bpm[31]) && (full[31] != op_a[i][31]),
                          full[31:0] == 32'h0};
        end
        tx = 0; rx = 0; cyc = 0;
        while (rx < 20 && cyc < 200) begin
            rdy_drv = !(cyc >= 8 && cyc <= 10);
            #1;
            m = mon(0);
            if (!rdy_drv) begin
                check($sformatf("stall%0d_ready", cyc), m.ready, 0);
                if (cyc == 8) held = m;
                else check($sformatf("stall%0d_hold", cyc), m, held);
            end
            if (m.valid && rdy_drv) begin
                check($sformatf("stream%0d_sum", rx), m.sum, exp_sum[rx]);
                check($sformatf("stream%0d_flags", rx), {m.cout, m.ovf, m.zero}, exp_flg[rx]);
                $display("txn stream %0d: sum=%h cout=%b ovf=%b zero=%b",
                         rx, m.sum, m.cout, m.ovf, m.zero);
                rx++;
            end
            if (tx < 20) begin
                a_drv = op_a[tx]; b_drv = op_b[tx]; cin_drv = op_c[tx]; sub_drv = op_s[tx];
                vld_drv[0] = 1'b1;
                if (m.ready) tx++;
            end else begin
                vld_drv[0] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("stream_count", rx, 20);
        check("stream_cycles", cyc, 27);
        rdy_drv = 1'b1;
        vld_drv = '0;

        // Flush with three ops in flight plus a fourth presented on the flush edge.
        cin_drv = 1'b0; sub_drv = 1'b0; b_drv = 32'h1;
        for (int i = 0; i < 3; i++) begin
            a_drv = 32'h100 * (i + 1);
            vld_drv[0] = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        a_drv = 32'h1234;
        @(negedge clk);
        flush = 1'b0;
        m = mon(0);
        check("flush_clear", m.valid, 0);
        a_drv = 32'h10; b_drv = 32'h20;
        for (int k = 1; k <= LAT32 + 3; k++) begin
            @(negedge clk);
            if (k == 1) vld_drv[0] = 1'b0;
            m = mon(0);
            check($sformatf("post_flush_v%0d", k), m.valid, (k == LAT32));
            if (k == LAT32) check("post_flush_sum", m.sum, 32'h30);
        end
        $display("txn post_flush: sum=%h", 32'h30);

        single(1, LAT16, "w16_ovf", 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_8000, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a W16 stream.
        a_drv = 32'h1111; b_drv = 32'h2222; cin_drv = 1'b0; sub_drv = 1'b0;
        vld_drv[1] = 1'b1;
        repeat (6) @(negedge clk);
        m = mon(1);
        check("w16_pre_rst_valid", m.valid, 1);
        check("w16_pre_rst_sum", m.sum, 32'h3333);
        #2;
        rst_n = 1'b0;
        vld_drv = '0;
        #1;
        m = mon(1);
        check("async_rst_valid", m.valid, 0);
        check("async_rst_sum", m.sum, 0);
        check("async_rst_ready", m.ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= LAT16 + 1; k++) begin
            @(negedge clk);
            m = mon(1);
            check($sformatf("rst_discard_v%0d", k), m.valid, 0);
        end
        $display("txn async_reset: in-flight W16 ops discarded");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
